pulpino_boot_seq: RTL

//  Reset and boot sequencer directly upstream of the PULPino SoC wrapper on the FPGA.
//  - Generates the SoC reset (rst_n) and fetch enable (fetch_enable_i) from three raw board signals: PLL lock, reset button, fetch switch.
//  - Guarantees a minimum reset pulse and a fixed delay from reset release to first instruction fetch.

---
 rtl/pulpino_boot_seq_if.sv | 36 +++
 rtl/pulpino_boot_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pulpino_boot_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : pulpino_boot_seq_if
// Brief   : Board-side inputs and SoC-side outputs of the boot sequencer.
// Rev     : 1.0
// ============================================================================
interface pulpino_boot_seq_if;
    logic       pll_locked_i;
    logic       btn_rst_i;
    logic       fetch_req_i;
    logic       soc_rst_n_o;
    logic       fetch_enable_o;
    logic       boot_done_o;
    logic [1:0] state_o;

    modport master (
        input  pll_locked_i,
        input  btn_rst_i,
        input  fetch_req_i,
        output soc_rst_n_o,
        output fetch_enable_o,
        output boot_done_o,
        output state_o
    );

    modport slave (
        output pll_locked_i,
        output btn_rst_i,
        output fetch_req_i,
        input  soc_rst_n_o,
        input  fetch_enable_o,
        input  boot_done_o,
        input  state_o
    );
endinterface
`default_nettype wire

// File: rtl/pulpino_boot_seq.sv
`default_nettype none
// ============================================================================
// Module  : pulpino_boot_seq
// Brief   : Synchronises/debounces board lock, button and fetch switch, then
//           stretches SoC reset and gates the first instruction fetch.
// Rev     : 1.0
// ============================================================================
module pulpino_boot_seq #(
    parameter int RST_HOLD_CYCLES    = 1024,
    parameter int FETCH_DELAY_CYCLES = 256,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int CNT_W              = 16
) (
    input  wire                clk,
    input  wire                rst_n,
    pulpino_boot_seq_if.master bus
);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_DELAY     = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_deb_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(RST_HOLD_CYCLES - 1);
    // Delay counter tops out one past the nominal delay so fetch comes at least
    // FETCH_DELAY_CYCLES+1 cycles after SoC reset release.
    localparam logic [CNT_W-1:0] c_fetch_gate = CNT_W'(FETCH_DELAY_CYCLES);

    logic             r_pll_s1;
    logic             r_pll_s2;
    logic [1:0]       w_raw;
    logic [1:0]       w_db;
    logic             r_btn_db_d;
    logic             w_btn_rise;
    logic             w_fetch_db;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_soc_rst_n;
    logic             r_fetch_en;
    logic             w_soc_rst_n_nxt;
    logic             w_fetch_en_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_s1 <= 1'b0;
            r_pll_s2 <= 1'b0;
        end else begin
            r_pll_s1 <= bus.pll_locked_i;
            r_pll_s2 <= r_pll_s1;
        end
    end

    assign w_raw = {bus.fetch_req_i, bus.btn_rst_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic             r_s1;
        logic             r_s2;
        logic             r_db;
        logic [CNT_W-1:0] r_dcnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_db   <= 1'b0;
                r_dcnt <= '0;
            end else begin
                r_s1 <= w_raw[gi];
                r_s2 <= r_s1;
                if (r_s2 == r_db) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == c_deb_last) begin
                    r_db   <= r_s2;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + c_one;
                end
            end
        end

        assign w_db[gi] = r_db;
    end

    assign w_fetch_db = w_db[1];
    assign w_btn_rise = w_db[0] & ~r_btn_db_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_db_d  <= 1'b0;
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_soc_rst_n <= 1'b0;
            r_fetch_en  <= 1'b0;
        end else begin
            r_btn_db_d  <= w_db[0];
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_soc_rst_n <= w_soc_rst_n_nxt;
            r_fetch_en  <= w_fetch_en_nxt;
        end
    end

    // Lock loss beats the button, which beats the normal sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!r_pll_s2) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
        end else if (w_btn_rise) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
                S_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == c_fetch_gate) begin
                        if (w_fetch_db) begin
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
                S_RUN: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        w_soc_rst_n_nxt = (w_state_nxt == S_DELAY) || (w_state_nxt == S_RUN);
        w_fetch_en_nxt  = (w_state_nxt == S_RUN) && w_fetch_db;
    end

    assign bus.soc_rst_n_o    = r_soc_rst_n;
    assign bus.fetch_enable_o = r_fetch_en;
    assign bus.boot_done_o    = (r_state == S_RUN);
    assign bus.state_o        = r_state;

endmodule
`default_nettype wire
